// File: rtl/sdlib.sv
// Shared definitions for the sd_* pulse-handling blocks: FSM state encoding,
// gap-timer width and the legal GAP range.
package sdlib;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } sd_state_e;

  localparam int SD_TIMER_W = 8;
  localparam int SD_GAP_MIN = 2;
  localparam int SD_GAP_MAX = 255;

  function automatic bit sd_gap_legal(input int gap);
    return (gap >= SD_GAP_MIN) && (gap <= SD_GAP_MAX);
  endfunction

endpackage

// File: rtl/sd_pulse_spacer_if.sv
// Request/status bundle between a pulse producer and sd_pulse_spacer.
interface sd_pulse_spacer_if #(
  parameter int CNT_W = 4
) ();

  logic             pulse_in;
  logic             ovf_clr;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             idle;

  modport master (
    output pulse_in,
    output ovf_clr,
    input  pulse_out,
    input  pending,
    input  overflow,
    input  idle
  );

  modport slave (
    input  pulse_in,
    input  ovf_clr,
    output pulse_out,
    output pending,
    output overflow,
    output idle
  );

endinterface

// File: rtl/sd_sat_counter.sv
// Up/down counter that sticks at both ends instead of wrapping; simultaneous
// inc and dec cancel.
module sd_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != CNT_MAX)) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

endmodule

// File: rtl/sd_pulse_spacer.sv
// Re-spaces a bursty pulse stream so consecutive pulse_out rising edges are at
// least GAP cycles apart, queueing up to 2**CNT_W-1 requests.
module sd_pulse_spacer
  import sdlib::*;
#(
  parameter int GAP   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  sd_pulse_spacer_if.slave bus
);

  if (!sd_gap_legal(GAP)) begin : g_gap_range
    $error("sd_pulse_spacer: GAP=%0d outside %0d..%0d", GAP, SD_GAP_MIN, SD_GAP_MAX);
  end

  // HOLD spans GAP-1 cycles: the timer is loaded on entry and exits at zero.
  localparam logic [SD_TIMER_W-1:0] HOLD_LOAD = SD_TIMER_W'(GAP - 2);

  sd_state_e             state_q, state_d;
  logic [SD_TIMER_W-1:0] timer_q, timer_d;
  logic                  pulse_out_q, pulse_out_d;
  logic                  overflow_q, overflow_d;

  logic             fire;
  logic             drop;
  logic             want_fire;
  logic [CNT_W-1:0] cnt;
  logic             cnt_full;
  logic             cnt_empty;

  assign fire      = (state_q == ST_FIRE);
  // A FIRE cycle frees a slot, so a request arriving then is never dropped.
  assign drop      = bus.pulse_in && cnt_full && !fire;
  assign want_fire = bus.pulse_in || !cnt_empty;

  sd_sat_counter #(
    .W (CNT_W)
  ) u_pending (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (bus.pulse_in),
    .dec   (fire),
    .count (cnt),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (want_fire) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
        timer_d = HOLD_LOAD;
      end
      ST_HOLD: begin
        if (timer_q != '0) begin
          timer_d = timer_q - SD_TIMER_W'(1);
        end else if (want_fire) begin
          state_d = ST_FIRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    pulse_out_d = (state_d == ST_FIRE);
    // A drop in the same cycle as a clear must leave the flag set.
    overflow_d  = drop || (overflow_q && !bus.ovf_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pulse_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pulse_out_q <= pulse_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.pulse_out = pulse_out_q;
  assign bus.pending   = cnt;
  assign bus.overflow  = overflow_q;
  assign bus.idle      = (state_q == ST_IDLE) && cnt_empty;

  a_fire_has_pending: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_FIRE) |-> !cnt_empty);

  a_pulse_is_fire: assert property (@(posedge clk) disable iff (!reset_n)
    pulse_out_q == (state_q == ST_FIRE));

endmodule
